// File: rtl/taillight_sequencer.sv
// taillight_sequencer: turn-signal lamp controller.
// Arbitrates left/right requests (both together = hazard), paces lamp steps
// with a free-running prescaler and drives three lamps per side in the
// classic sequential pattern.
// Optional feature macro: TAILLIGHT_BRAKE_EN adds a 'brake' input that lights
// every side not currently sequencing (hazard ignores brake).
module taillight_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
`ifdef TAILLIGHT_BRAKE_EN
  input  logic brake,
`endif
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic busy,
  output logic step_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  logic [CW-1:0] cnt;
  logic          tick;
  state_t        state;
  state_t        next_state;
  logic          brake_in;
  logic [5:0]    lamp_next;
  logic          left_seq;
  logic          right_seq;

`ifdef TAILLIGHT_BRAKE_EN
  assign brake_in = brake;
`else
  assign brake_in = 1'b0;
`endif

  assign tick = (cnt == CNT_LAST);

  // Free-running prescaler, independent of the sequencer state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Step boundary pulse: registered copy of the prescaler wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_tick <= 1'b0;
    end else begin
      step_tick <= tick;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: requests are only looked at from IDLE on a tick; a started
  // sequence always runs to completion
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tick) begin
          if (left && right) begin
            next_state = HAZ;
          end else if (left) begin
            next_state = L1;
          end else if (right) begin
            next_state = R1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      L1:  if (tick) next_state = L2;
      L2:  if (tick) next_state = L3;
      L3:  if (tick) next_state = IDLE;
      R1:  if (tick) next_state = R2;
      R2:  if (tick) next_state = R3;
      R3:  if (tick) next_state = IDLE;
      HAZ: if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lamp decode of the upcoming state plus brake overlay on idle sides
  always_comb begin
    lamp_next = 6'b000000;
    left_seq  = (next_state == L1) || (next_state == L2) || (next_state == L3);
    right_seq = (next_state == R1) || (next_state == R2) || (next_state == R3);
    case (next_state)
      L1:      lamp_next = 6'b100_000;
      L2:      lamp_next = 6'b110_000;
      L3:      lamp_next = 6'b111_000;
      R1:      lamp_next = 6'b000_100;
      R2:      lamp_next = 6'b000_110;
      R3:      lamp_next = 6'b000_111;
      HAZ:     lamp_next = 6'b111_111;
      default: lamp_next = 6'b000_000;
    endcase
    if (brake_in && (next_state != HAZ)) begin
      if (!left_seq) begin
        lamp_next[5:3] = 3'b111;
      end
      if (!right_seq) begin
        lamp_next[2:0] = 3'b111;
      end
    end
  end

  // Lamp and busy registers track the state register with no extra lag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {la, lb, lc, ra, rb, rc} <= 6'b000000;
      busy                     <= 1'b0;
    end else begin
      {la, lb, lc, ra, rb, rc} <= lamp_next;
      busy                     <= (next_state != IDLE);
    end
  end

endmodule
